// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO controller with debounced inputs, edge/timer interrupts
// Register-mapped outputs with atomic set/clear, rising-edge capture and a compare timer.
module gpio_irq_ctrl #(
  parameter int                   IN_WIDTH        = 24,
  parameter int                   OUT_WIDTH       = 20,
  parameter int                   DEBOUNCE_CYCLES = 4,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 write_en,
  input  logic [11:0]          addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out,
  output logic                 irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  localparam logic [9:0] A_IN     = 10'h000;
  localparam logic [9:0] A_OUT    = 10'h001;
  localparam logic [9:0] A_SET    = 10'h002;
  localparam logic [9:0] A_CLR    = 10'h003;
  localparam logic [9:0] A_IRQ_EN = 10'h004;
  localparam logic [9:0] A_EDGE   = 10'h005;
  localparam logic [9:0] A_TIMER  = 10'h006;
  localparam logic [9:0] A_CMP    = 10'h007;
  localparam logic [9:0] A_CTRL   = 10'h008;

  logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
  logic [IN_WIDTH-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
  logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IN_WIDTH-1:0]  irq_en_q, irq_en_d;
  logic [IN_WIDTH-1:0]  edge_q, edge_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          cmp_q, cmp_d;
  logic                 ie_q, ie_d;
  logic                 hit_q, hit_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [31:0]          rdata;
  logic [IN_WIDTH-1:0]  rise, edge_w1c;
  logic [9:0]           word;
  logic                 wr, rd;
  logic                 unused_addr_lsb;

  assign word            = addr[11:2];
  assign wr              = en & write_en;
  assign rd              = en & ~write_en;
  assign unused_addr_lsb = ^addr[1:0];

  // A mismatch between sync and debounced must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise     = deb_d & ~deb_q;
  assign edge_w1c = (wr && word == A_EDGE) ? data_in[IN_WIDTH-1:0] : '0;

  always_comb begin
    out_d    = out_q;
    irq_en_d = irq_en_q;
    cmp_d    = cmp_q;
    ie_d     = ie_q;
    timer_d  = timer_q + 32'd1;
    hit_d    = hit_q;
    if (wr) begin
      case (word)
        A_OUT:    out_d    = data_in[OUT_WIDTH-1:0];
        A_SET:    out_d    = out_q | data_in[OUT_WIDTH-1:0];
        A_CLR:    out_d    = out_q & ~data_in[OUT_WIDTH-1:0];
        A_IRQ_EN: irq_en_d = data_in[IN_WIDTH-1:0];
        A_TIMER:  timer_d  = data_in;
        A_CMP:    cmp_d    = data_in;
        A_CTRL: begin
          ie_d  = data_in[1];
          hit_d = hit_q & ~data_in[0];
        end
        default: ;
      endcase
    end
    // Compare uses the pre-update timer and always beats a same-cycle clear.
    if (timer_q == cmp_q) hit_d = 1'b1;
    edge_d = (edge_q & ~edge_w1c) | rise;
  end

  always_comb begin
    rdata = '0;
    case (word)
      A_IN:     rdata = 32'(deb_q);
      A_OUT:    rdata = 32'(out_q);
      A_IRQ_EN: rdata = 32'(irq_en_q);
      A_EDGE:   rdata = 32'(edge_q);
      A_TIMER:  rdata = timer_q;
      A_CMP:    rdata = cmp_q;
      A_CTRL:   rdata = {30'd0, ie_q, hit_q};
      default:  rdata = '0;
    endcase
    data_out_d = rd ? rdata : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      out_q      <= OUT_RESET;
      irq_en_q   <= '0;
      edge_q     <= '0;
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      ie_q       <= 1'b0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      edge_q     <= edge_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      ie_q       <= ie_d;
      hit_q      <= hit_d;
      data_out_q <= data_out_d;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_out = data_out_q;
  assign gpio_out = out_q;
  assign irq      = (|(edge_q & irq_en_q)) | (hit_q & ie_q);

endmodule
